// File: rtl/core_pkg.sv
// Shared integer-datapath types and sizes for the RV32I core.
// Imported by the register file and its read ports.
package core_pkg;

  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int AW = $clog2(NREGS);

  typedef logic [XLEN-1:0] word_t;
  typedef logic [AW-1:0] reg_idx_t;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: storage lookup, x0 masking and
// optional same-cycle forwarding of the pending writeback value.
module regfile_read_port
  import core_pkg::*;
#(
  parameter int XLEN = core_pkg::XLEN,
  parameter int NREGS = core_pkg::NREGS,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic [AW-1:0]   idx_i,
  input  logic [XLEN-1:0] regs_i [NREGS],
  input  logic            wen_i,
  input  logic [AW-1:0]   rd_i,
  input  logic [XLEN-1:0] din_i,
  output logic [XLEN-1:0] rdata_o
);

  logic hit;

  assign hit = (BYPASS != 0) && wen_i &&
               (rd_i != AW'(REG_ZERO)) &&
               (idx_i == rd_i);

  always_comb begin
    rdata_o = regs_i[idx_i];
    if (hit) rdata_o = din_i;
    if (idx_i == AW'(REG_ZERO)) rdata_o = '0;
  end

endmodule

// File: rtl/register_file.sv
// 32 x XLEN integer register file: two async read ports,
// one sync write port, x0 hardwired to zero.
module register_file
  import core_pkg::*;
#(
  parameter int XLEN = core_pkg::XLEN,
  parameter int NREGS = core_pkg::NREGS,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wen,
  input  logic [AW-1:0]   rd,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [XLEN-1:0] din,
  output logic [XLEN-1:0] r1,
  output logic [XLEN-1:0] r2
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic            wen_d;

  // Reset must also suppress forwarding so reads stay 0.
  assign wen_d = wen && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wen && (rd != AW'(REG_ZERO))) begin
      regs_q[rd] <= din;
    end
  end

  regfile_read_port #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .BYPASS(BYPASS)
  ) u_rp1 (
    .idx_i  (rs1),
    .regs_i (regs_q),
    .wen_i  (wen_d),
    .rd_i   (rd),
    .din_i  (din),
    .rdata_o(r1)
  );

  regfile_read_port #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .BYPASS(BYPASS)
  ) u_rp2 (
    .idx_i  (rs2),
    .regs_i (regs_q),
    .wen_i  (wen_d),
    .rd_i   (rd),
    .din_i  (din),
    .rdata_o(r2)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file with a queue-based
// scoreboard and a separate sampling monitor.
module tb_register_file;

  logic        clk;
  logic        clk_en;
  logic        rst;
  logic        wen;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] din;
  logic [31:0] r1;
  logic [31:0] r2;

  typedef struct {
    string       name;
    logic [31:0] e1;
    logic [31:0] e2;
    bit          c1;
    bit          c2;
  } exp_t;

  exp_t sb_q[$];
  event chk_ev;
  int   n_chk;
  int   n_fail;

  register_file #(.BYPASS(1)) dut (
    .clk(clk),
    .rst(rst),
    .wen(wen),
    .rd (rd),
    .rs1(rs1),
    .rs2(rs2),
    .din(din),
    .r1 (r1),
    .r2 (r2)
  );

  initial clk = 1'b0;
  always begin
    #10;
    if (clk_en) clk = ~clk;
  end

  // Monitor: samples outputs shortly after each request.
  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      #1;
      while (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        if (e.c1) begin
          n_chk++;
          if (r1 !== e.e1) begin
            n_fail++;
            $display("FAIL %s r1: got %h expected %h",
                     e.name, r1, e.e1);
          end
        end
        if (e.c2) begin
          n_chk++;
          if (r2 !== e.e2) begin
            n_fail++;
            $display("FAIL %s r2: got %h expected %h",
                     e.name, r2, e.e2);
          end
        end
      end
    end
  end

  task automatic expect_rd(input string name,
                           input logic [31:0] e1,
                           input logic [31:0] e2,
                           input bit c1, input bit c2);
    exp_t e;
    e.name = name;
    e.e1 = e1;
    e.e2 = e2;
    e.c1 = c1;
    e.c2 = c2;
    sb_q.push_back(e);
    ->chk_ev;
    for (int k = 0; k < 8 && sb_q.size() != 0; k++) #1;
    if (sb_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s timeout: queue %0d expected 0",
               name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    clk_en = 1'b0;
    rst = 1'b0;
    wen = 1'b0;
    rd = '0;
    rs1 = '0;
    rs2 = '0;
    din = '0;
    #3;

    // Reset with clock idle
    rs1 = 5'd9;
    rs2 = 5'd31;
    rst = 1'b1;
    #2;
    expect_rd("rst_hold", 32'h0, 32'h0, 1, 1);
    rst = 1'b0;
    #2;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i);
      rs2 = 5'(31 - i);
      expect_rd("rst_sweep", 32'h0, 32'h0, 1, 1);
    end

    clk_en = 1'b1;
    @(negedge clk);

    // Basic write x10
    rd = 5'd10;
    din = 32'hBABEFACE;
    wen = 1'b1;
    edge_step();
    wen = 1'b0;
    rs1 = 5'd2;
    rs2 = 5'd10;
    expect_rd("wr_x10", 32'h0, 32'hBABEFACE, 1, 1);

    // Second write x2
    rd = 5'd2;
    wen = 1'b1;
    edge_step();
    wen = 1'b0;
    expect_rd("wr_x2", 32'hBABEFACE, 32'hBABEFACE, 1, 1);

    // x0 write ignored, no bypass on x0
    rd = 5'd0;
    din = 32'hDEADBEEF;
    wen = 1'b1;
    rs1 = 5'd0;
    rs2 = 5'd0;
    expect_rd("x0_pre", 32'h0, 32'h0, 1, 1);
    edge_step();
    wen = 1'b0;
    expect_rd("x0_post", 32'h0, 32'h0, 1, 1);

    // Bypass both ports before the edge
    rd = 5'd5;
    din = 32'h12345678;
    wen = 1'b1;
    rs1 = 5'd5;
    rs2 = 5'd5;
    expect_rd("byp_pre", 32'h12345678, 32'h12345678, 1, 1);
    edge_step();
    wen = 1'b0;
    din = 32'h0;
    expect_rd("byp_post", 32'h12345678, 32'h12345678, 1, 1);

    // Bypass on one port only
    rd = 5'd10;
    din = 32'h0F0F0F0F;
    wen = 1'b1;
    rs1 = 5'd5;
    rs2 = 5'd10;
    expect_rd("byp_one", 32'h12345678, 32'h0F0F0F0F, 1, 1);
    edge_step();

    // wen=0 leaves storage alone
    wen = 1'b0;
    rd = 5'd5;
    din = 32'hFFFFFFFF;
    expect_rd("nowen_pre", 32'h12345678, 32'h0F0F0F0F, 1, 1);
    edge_step();
    expect_rd("nowen_post", 32'h12345678, 32'h0F0F0F0F, 1, 1);

    // Reset during a write
    rd = 5'd7;
    din = 32'hCAFEF00D;
    wen = 1'b1;
    edge_step();
    rs1 = 5'd7;
    rs2 = 5'd2;
    din = 32'h11111111;
    expect_rd("x7_byp", 32'h11111111, 32'hBABEFACE, 1, 1);
    wen = 1'b0;
    expect_rd("x7_stored", 32'hCAFEF00D, 32'hBABEFACE, 1, 1);
    wen = 1'b1;
    rst = 1'b1;
    #2;
    expect_rd("rst_mid", 32'h0, 32'h0, 1, 1);
    edge_step();
    edge_step();
    expect_rd("rst_held", 32'h0, 32'h0, 1, 1);
    wen = 1'b0;
    rst = 1'b0;
    rs2 = 5'd10;
    #2;
    expect_rd("rst_after", 32'h0, 32'h0, 1, 1);

    // Write after reset
    @(negedge clk);
    rd = 5'd3;
    din = 32'hA5A5A5A5;
    wen = 1'b1;
    edge_step();
    wen = 1'b0;
    rs1 = 5'd3;
    rs2 = 5'd7;
    expect_rd("wr_x3", 32'hA5A5A5A5, 32'h0, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
